pipe_stall_ctrl: RTL and testbench

//  Central pipeline sequencer for the 6-stage core (pc/if/id/ex/mem/wb).

---
 rtl/pipe_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges id/ex stall requests onto the shared
// stall bus, runs two-cycle madd ops and the divider handshake with a timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no multi-cycle op in ex; madd/div requests are accepted here
// MADD2    | second madd/msub cycle, ex works from the hilo temp
// DIV_BUSY | divider running, ex frozen until ready, flush or timeout
module pipe_stall_ctrl #(
   parameter int N_STALL     = 6,
   parameter int N_PC        = 32,
   parameter int DIV_TIMEOUT = 40
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_id_stall_req,
   input  logic               i_ex_op_madd,
   input  logic               i_ex_op_div,
   input  logic               i_div_ready,
   input  logic               i_flush_req,
   input  logic [N_PC-1:0]    i_exc_pc,
   output logic [N_STALL-1:0] o_stall,
   output logic               o_flush,
   output logic [N_PC-1:0]    o_new_pc,
   output logic               o_madd_phase,
   output logic               o_div_start,
   output logic               o_div_annul,
   output logic               o_div_err
);

   localparam int CW = $clog2(DIV_TIMEOUT + 1);
   localparam logic [N_STALL-1:0] STALL_ID = N_STALL'(7);
   localparam logic [N_STALL-1:0] STALL_EX = N_STALL'(15);
   localparam logic [CW-1:0]      CNT_TC   = CW'(DIV_TIMEOUT);

   typedef enum logic [1:0] {IDLE, MADD2, DIV_BUSY} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            div_err_q;
   logic            timeout_hit;
   logic [N_STALL-1:0] stall_rel;

   // ready in the terminal cycle counts as a normal completion
   assign timeout_hit = (state == DIV_BUSY) && !i_div_ready && !i_flush_req
                        && (cnt == CNT_TC);
   assign stall_rel   = i_id_stall_req ? STALL_ID : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         div_err_q <= 1'b0;
      end else if (i_flush_req) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_ex_op_madd) begin
                  state <= MADD2;
               end else if (i_ex_op_div) begin
                  state <= DIV_BUSY;
                  cnt   <= CW'(1);
               end
            end
            MADD2: state <= IDLE;
            DIV_BUSY: begin
               if (i_div_ready) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_TC) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  div_err_q <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      o_stall      = '0;
      o_flush      = 1'b0;
      o_new_pc     = '0;
      o_madd_phase = 1'b0;
      o_div_start  = 1'b0;
      o_div_annul  = 1'b0;
      o_div_err    = div_err_q | timeout_hit;
      if (i_flush_req) begin
         o_flush     = 1'b1;
         o_new_pc    = i_exc_pc;
         o_div_annul = (state == DIV_BUSY);
      end else begin
         case (state)
            IDLE: begin
               if (i_ex_op_madd) begin
                  o_stall = STALL_EX;
               end else if (i_ex_op_div) begin
                  o_stall     = STALL_EX;
                  o_div_start = 1'b1;
               end else begin
                  o_stall = stall_rel;
               end
            end
            MADD2: begin
               o_madd_phase = 1'b1;
               o_stall      = stall_rel;
            end
            DIV_BUSY: begin
               if (i_div_ready) begin
                  o_stall = stall_rel;
               end else if (timeout_hit) begin
                  o_div_annul = 1'b1;
                  o_stall     = stall_rel;
               end else begin
                  o_stall     = STALL_EX;
                  o_div_start = 1'b1;
               end
            end
            default: o_stall = '0;
         endcase
      end
      // reset forces a quiet bus even while requests are still asserted
      if (!i_rst_n) begin
         o_stall      = '0;
         o_flush      = 1'b0;
         o_new_pc     = '0;
         o_madd_phase = 1'b0;
         o_div_start  = 1'b0;
         o_div_annul  = 1'b0;
         o_div_err    = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: each driven cycle queues its expected
// outputs, a negedge monitor pops and compares them.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_req = 1'b0, op_madd = 1'b0, op_div = 1'b0, div_rdy = 1'b0, flush_req = 1'b0;
   logic [31:0] exc_pc = '0;
   logic [5:0]  stall;
   logic        flush, madd_phase, div_start, div_annul, div_err;
   logic [31:0] new_pc;

   localparam logic [5:0] S0  = 6'b000000;
   localparam logic [5:0] SID = 6'b000111;
   localparam logic [5:0] SEX = 6'b001111;
   localparam logic [4:0] I_NONE = 5'b00000, I_ID = 5'b10000, I_MADD = 5'b01000,
                          I_DIV = 5'b00100, I_RDY = 5'b00010, I_FL = 5'b00001;
   localparam logic [31:0] JUNK_PC = 32'hdead_beef;

   typedef struct {
      string       tag;
      logic [10:0] o;
      logic [31:0] pc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic er = 1'b0;

   wire [10:0] obs = {stall, flush, madd_phase, div_start, div_annul, div_err};

   pipe_stall_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_id_stall_req(id_req), .i_ex_op_madd(op_madd),
      .i_ex_op_div(op_div), .i_div_ready(div_rdy), .i_flush_req(flush_req),
      .i_exc_pc(exc_pc), .o_stall(stall), .o_flush(flush), .o_new_pc(new_pc),
      .o_madd_phase(madd_phase), .o_div_start(div_start), .o_div_annul(div_annul),
      .o_div_err(div_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [5:0] s, input logic f, input logic ph,
                                       input logic st, input logic an, input logic ev);
      return {s, f, ph, st, an, ev};
   endfunction

   task automatic cyc(input string tag, input logic [4:0] in, input logic [31:0] pc,
                      input logic [10:0] e_out, input logic [31:0] e_pc);
      exp_t x;
      @(posedge clk);
      #1;
      {id_req, op_madd, op_div, div_rdy, flush_req} = in;
      exc_pc = pc;
      x.tag = tag;
      x.o   = e_out;
      x.pc  = e_pc;
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         chk($sformatf("%s out", e.tag), 64'(obs), 64'(e.o));
         chk($sformatf("%s pc", e.tag), 64'(new_pc), 64'(e.pc));
      end
   end

   task automatic idle_out(input string tag);
      cyc(tag, I_NONE, JUNK_PC, mk(S0, 0, 0, 0, 0, er), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      {id_req, op_madd, op_div} = 3'b111;
      #12;
      chk("reset_hold", 64'({obs, new_pc}), 64'd0);
      {id_req, op_madd, op_div} = 3'b000;
      #6 rst_n = 1'b1;
      #1 chk("reset_rel", 64'({obs, new_pc}), 64'd0);

      // id load-use only
      cyc("id", I_ID, JUNK_PC, mk(SID, 0, 0, 0, 0, 0), '0);
      idle_out("id_after");

      // madd: two ex cycles, then idle
      cyc("madd0", I_MADD, JUNK_PC, mk(SEX, 0, 0, 0, 0, 0), '0);
      cyc("madd1", I_MADD, JUNK_PC, mk(S0, 0, 1, 0, 0, 0), '0);
      idle_out("madd2");
      // madd with id request: ignored in cycle0, honoured in second phase
      cyc("maddid0", I_MADD | I_ID, JUNK_PC, mk(SEX, 0, 0, 0, 0, 0), '0);
      cyc("maddid1", I_ID, JUNK_PC, mk(SID, 0, 1, 0, 0, 0), '0);
      // illegal madd+div: madd wins, no divider start
      cyc("both0", I_MADD | I_DIV, JUNK_PC, mk(SEX, 0, 0, 0, 0, 0), '0);
      cyc("both1", I_NONE, JUNK_PC, mk(S0, 0, 1, 0, 0, 0), '0);
      idle_out("both2");

      // div with ready at cycle 33, then back-to-back div
      cyc("div0", I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 0), '0);
      for (int k = 1; k <= 32; k++)
         cyc($sformatf("div_busy%0d", k), I_DIV | ((k == 7) ? I_ID : I_NONE), JUNK_PC,
             mk(SEX, 0, 0, 1, 0, 0), '0);
      cyc("div_rdy", I_DIV | I_RDY, JUNK_PC, mk(S0, 0, 0, 0, 0, 0), '0);
      cyc("div2_0", I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 0), '0);
      cyc("div2_1", I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 0), '0);
      cyc("div2_rdy", I_RDY | I_ID, JUNK_PC, mk(SID, 0, 0, 0, 0, 0), '0);
      idle_out("div2_idle");

      // flush at cycle 5 of a div
      cyc("fdiv0", I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 0), '0);
      for (int k = 1; k <= 4; k++)
         cyc($sformatf("fdiv%0d", k), I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 0), '0);
      cyc("fdiv_flush", I_DIV | I_FL, 32'h0000_0040, mk(S0, 1, 0, 0, 1, 0), 32'h40);
      idle_out("fdiv_idle");
      // flush in IDLE beats a div request and annuls nothing
      cyc("fidle", I_DIV | I_FL, 32'h0000_1234, mk(S0, 1, 0, 0, 0, 0), 32'h1234);
      idle_out("fidle_after");
      // flush in MADD2 drops the phase flag
      cyc("fmadd0", I_MADD, JUNK_PC, mk(SEX, 0, 0, 0, 0, 0), '0);
      cyc("fmadd1", I_FL, 32'h8000_0180, mk(S0, 1, 0, 0, 0, 0), 32'h8000_0180);
      idle_out("fmadd2");

      // divider timeout, no ready
      cyc("to0", I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 0), '0);
      for (int k = 1; k <= 39; k++)
         cyc($sformatf("to%0d", k), I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 0), '0);
      cyc("to40", I_NONE, JUNK_PC, mk(S0, 0, 0, 0, 1, 1), '0);
      er = 1'b1;
      idle_out("to41");
      cyc("to_sticky_id", I_ID, JUNK_PC, mk(SID, 0, 0, 0, 0, 1), '0);

      // async reset inside DIV_BUSY clears the sticky error
      cyc("rdiv0", I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 1), '0);
      cyc("rdiv1", I_DIV, JUNK_PC, mk(SEX, 0, 0, 1, 0, 1), '0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_div", 64'({obs, new_pc}), 64'd0);
      op_div = 1'b0;
      #4 rst_n = 1'b1;
      er = 1'b0;
      idle_out("rst_div_after");

      // async reset inside MADD2, requests still asserted
      cyc("rmadd0", I_MADD, JUNK_PC, mk(SEX, 0, 0, 0, 0, 0), '0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_madd", 64'({obs, new_pc}), 64'd0);
      op_madd = 1'b0;
      #4 rst_n = 1'b1;
      idle_out("rst_madd_after");
      cyc("post_madd0", I_MADD, JUNK_PC, mk(SEX, 0, 0, 0, 0, 0), '0);
      cyc("post_madd1", I_NONE, JUNK_PC, mk(S0, 0, 1, 0, 0, 0), '0);

      @(negedge clk);
      @(negedge clk);
      chk("drain", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
